// File: rtl/speech256_pkg.sv
// speech256_pkg: shared allophone width, pause code and queue FSM state type
package speech256_pkg;
  localparam int ALLOPHONE_W = 6;
  localparam logic [ALLOPHONE_W-1:0] PAUSE_CODE = 6'h00;
  typedef enum logic {IDLE, WAIT_ACK} q_state_t;
endpackage

// File: rtl/allophone_fifo.sv
// allophone_fifo: synchronous FIFO (wr/pop/flush; head, level, full, empty, overflow pulse)
module allophone_fifo
  import speech256_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                   clk,
  input  logic                   rst_an,
  input  logic [ALLOPHONE_W-1:0] wr_data,
  input  logic                   wr,
  input  logic                   pop,
  input  logic                   flush,
  output logic [ALLOPHONE_W-1:0] head,
  output logic [DEPTH_LOG2:0]    level,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [ALLOPHONE_W-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic push, take;
  assign full  = level == (DEPTH_LOG2 + 1)'(DEPTH);
  assign empty = level == '0;
  assign head  = mem[rd_ptr];
  assign push  = wr & ~full & ~flush;
  assign take  = pop & ~empty & ~flush;
  always_ff @(posedge clk or negedge rst_an)
    if (!rst_an) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr & full & ~flush;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (take) rd_ptr <= rd_ptr + 1'b1;
        level <= level + (DEPTH_LOG2 + 1)'(push) - (DEPTH_LOG2 + 1)'(take);
      end
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/allophone_queue.sv
// allophone_queue: host allophone FIFO feeding Speech256 data_in/data_stb, paced by ldq.
// Ports: clk, rst_an (async active-low); host side wr_data/wr_stb/flush;
// synth side ldq -> data_out/data_stb; status full/empty/level/overflow.
// Option: ALLOPHONE_QUEUE_AUTOPAUSE_EN issues PAUSE_CODE once the queue drains after real codes.
module allophone_queue
  import speech256_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                   clk,
  input  logic                   rst_an,
  input  logic [ALLOPHONE_W-1:0] wr_data,
  input  logic                   wr_stb,
  input  logic                   flush,
  input  logic                   ldq,
  output logic [ALLOPHONE_W-1:0] data_out,
  output logic                   data_stb,
  output logic                   full,
  output logic                   empty,
  output logic [DEPTH_LOG2:0]    level,
  output logic                   overflow
);
  logic [ALLOPHONE_W-1:0] head, out_nxt;
  logic pop, pause, stb_nxt;
  q_state_t state, state_nxt;
  allophone_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk(clk), .rst_an(rst_an), .wr_data(wr_data), .wr(wr_stb), .pop(pop), .flush(flush),
    .head(head), .level(level), .full(full), .empty(empty), .overflow(overflow)
  );
`ifdef ALLOPHONE_QUEUE_AUTOPAUSE_EN
  logic flag, flag_nxt;
  // a host write arriving this cycle beats the pause; it is issued next cycle instead
  assign pause = flag & empty & ~wr_stb;
  always_ff @(posedge clk or negedge rst_an)
    if (!rst_an) flag <= 1'b0;
    else flag <= flag_nxt;
`else
  assign pause = 1'b0;
`endif
  always_comb begin
    state_nxt = state;
    stb_nxt   = 1'b0;
    out_nxt   = data_out;
    pop       = 1'b0;
`ifdef ALLOPHONE_QUEUE_AUTOPAUSE_EN
    flag_nxt  = flag;
`endif
    if (state == IDLE) begin
      if (ldq && !flush && (!empty || pause)) begin
        pop       = !empty;
        out_nxt   = empty ? PAUSE_CODE : head;
        stb_nxt   = 1'b1;
        state_nxt = WAIT_ACK;
`ifdef ALLOPHONE_QUEUE_AUTOPAUSE_EN
        flag_nxt  = empty ? 1'b0 : (flag | (head != PAUSE_CODE));
`endif
      end
    end else if (!ldq) state_nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_an)
    if (!rst_an) begin
      state    <= IDLE;
      data_out <= '0;
      data_stb <= 1'b0;
    end else begin
      state    <= state_nxt;
      data_out <= out_nxt;
      data_stb <= stb_nxt;
    end
endmodule

// File: tb/tb_allophone_queue.sv
// tb_allophone_queue: directed stimulus with a scoreboard of expected issued codes
module tb_allophone_queue;
  logic clk = 1'b0, rst_an = 1'b0, wr_stb = 1'b0, flush = 1'b0, ldq = 1'b0;
  logic [5:0] wr_data = '0;
  logic [5:0] data_out;
  logic data_stb, full, empty, overflow, prev_stb = 1'b0;
  logic [4:0] level;
  logic [5:0] exp_q [$];
  int total = 0, bad = 0, stb_seen = 0, pushes = 0;

  allophone_queue #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .rst_an(rst_an), .wr_data(wr_data), .wr_stb(wr_stb), .flush(flush), .ldq(ldq),
    .data_out(data_out), .data_stb(data_stb), .full(full), .empty(empty), .level(level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_an && data_stb) begin
      logic [5:0] e;
      stb_seen++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_stb got=%0h want=no_strobe", data_out);
      end else begin
        e = exp_q.pop_front();
        if (data_out !== e) begin
          bad++;
          $display("FAIL stb_code got=%0h want=%0h", data_out, e);
        end
      end
      total++;
      if (prev_stb) begin
        bad++;
        $display("FAIL stb_width got=2+cycles want=1");
      end
    end
    prev_stb = rst_an && data_stb;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  task automatic expect_code(input logic [5:0] c);
    exp_q.push_back(c);
    pushes++;
  endtask

  task automatic write(input logic [5:0] c);
    wr_data = c;
    wr_stb = 1'b1;
    tick();
    wr_stb = 1'b0;
  endtask

  task automatic wait_stb();
    for (int i = 0; i < 8; i++) begin
      tick();
      if (data_stb) return;
    end
    total++;
    bad++;
    $display("FAIL stb_timeout got=none want=strobe");
  endtask

  initial begin
    repeat (3) tick();
    check("rst_empty", empty, 1);
    check("rst_level", level, 0);
    check("rst_full", full, 0);
    check("rst_stb", data_stb, 0);
    check("rst_out", data_out, 0);
    check("rst_ovf", overflow, 0);
    rst_an = 1'b1;
    tick();

    // single write, 2-clock write-to-strobe latency
    ldq = 1'b1;
    expect_code(6'h1B);
    write(6'h1B);
    check("w1_empty", empty, 0);
    check("w1_level", level, 1);
    check("w1_stb_early", data_stb, 0);
    tick();
    check("w1_stb", data_stb, 1);
    check("w1_out", data_out, 6'h1B);
    tick();
    check("w1_stb_low", data_stb, 0);
    check("w1_hold", data_out, 6'h1B);
    tick();
    ldq = 1'b0;
    tick();

    // fill with ldq low, then overflow
    for (int i = 0; i < 16; i++) begin
      expect_code(6'(8 + i * 3));
      write(6'(8 + i * 3));
    end
    check("fill_level", level, 16);
    check("fill_full", full, 1);
    check("fill_stb", data_stb, 0);
    write(6'h3F);
    check("ovf_pulse", overflow, 1);
    check("ovf_level", level, 16);
    tick();
    check("ovf_clear", overflow, 0);

    // write into full FIFO while a pop happens
    ldq = 1'b1;
    write(6'h3E);
    check("popw_ovf", overflow, 1);
    check("popw_level", level, 15);
    check("popw_full", full, 0);
    check("popw_stb", data_stb, 1);
    check("popw_out", data_out, 6'h08);

    for (int i = 0; i < 15; i++) begin
      ldq = 1'b0;
      tick();
      ldq = 1'b1;
      wait_stb();
    end
    ldq = 1'b0;
    tick();
    check("drain_empty", empty, 1);
    check("drain_level", level, 0);
    check("drain_q", exp_q.size(), 0);

    // flush while WAIT_ACK with 5 entries behind
    for (int i = 0; i < 6; i++) begin
      if (i == 0) expect_code(6'h28);
      write(6'(40 + i));
    end
    ldq = 1'b1;
    wait_stb();
    tick();
    check("pre_flush_level", level, 5);
    flush = 1'b1;
    wr_data = 6'h15;
    wr_stb = 1'b1;
    tick();
    flush = 1'b0;
    wr_stb = 1'b0;
    check("flush_level", level, 0);
    check("flush_empty", empty, 1);
    check("flush_ovf", overflow, 0);
    check("flush_stb", data_stb, 0);
    ldq = 1'b0;
    tick();
`ifdef ALLOPHONE_QUEUE_AUTOPAUSE_EN
    expect_code(6'h00);
    ldq = 1'b1;
    wait_stb();
`else
    ldq = 1'b1;
`endif
    repeat (3) tick();
    ldq = 1'b0;
    tick();
    ldq = 1'b1;
    repeat (4) tick();
    ldq = 1'b0;
    tick();

    // single code then (autopause) trailing pause
    expect_code(6'h2A);
`ifdef ALLOPHONE_QUEUE_AUTOPAUSE_EN
    expect_code(6'h00);
`endif
    write(6'h2A);
    ldq = 1'b1;
    wait_stb();
    check("ap_first", data_out, 6'h2A);
    ldq = 1'b0;
    tick();
    ldq = 1'b1;
`ifdef ALLOPHONE_QUEUE_AUTOPAUSE_EN
    wait_stb();
    check("ap_pause", data_out, 6'h00);
`endif
    repeat (4) tick();
    ldq = 1'b0;
    tick();
    check("sb_empty", exp_q.size(), 0);
    check("stb_count", stb_seen, pushes);

    // asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) write(6'(17 + i));
    exp_q.push_back(6'h11);
    ldq = 1'b1;
    wait_stb();
    #2 rst_an = 1'b0;
    #1;
    check("arst_empty", empty, 1);
    check("arst_level", level, 0);
    check("arst_stb", data_stb, 0);
    check("arst_out", data_out, 0);
    exp_q.delete();
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
